// File: rtl/nios_dbg_cmd_sysclk.sv
// System-clock side of the Nios II JTAG debug slave: synchronises the virtual-JTAG
// update strobes, latches IR/DR and issues one decoded action pulse per command.
module nios_dbg_cmd_sysclk #(
  parameter int IR_WIDTH    = 2,
  parameter int DATA_WIDTH  = 38,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IR_WIDTH-1:0]   ir_in,
  input  logic [DATA_WIDTH-1:0] sr,
  input  logic                  vs_uir,
  input  logic                  vs_udr,
  input  logic                  core_busy,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] jdo,
  output logic [NUM_CH-1:0]     take_action,
  output logic [NUM_CH-1:0]     take_no_action,
  output logic                  cmd_pending,
  output logic                  overrun,
  output logic                  bad_ir
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                  state_r;
  logic [SYNC_STAGES-1:0]  uir_sync_r;
  logic [SYNC_STAGES-1:0]  udr_sync_r;
  logic                    uir_hist_r;
  logic                    udr_hist_r;
  logic                    uir_p_r;
  logic                    udr_p_r;
  logic [IR_WIDTH-1:0]     ir_reg_r;
  logic [DATA_WIDTH-1:0]   jdo_r;
  logic [NUM_CH-1:0]       take_action_r;
  logic [NUM_CH-1:0]       take_no_action_r;
  logic                    cmd_pending_r;
  logic                    overrun_r;
  logic                    bad_ir_r;
  logic                    ir_legal_s;
  logic                    overrun_set_s;
  logic                    bad_ir_set_s;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IR_WIDTH-1:0] code);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v[i] = (code == IR_WIDTH'(i));
    end
    return v;
  endfunction

  // Channel legality and sticky-error set conditions.
  always_comb begin
    ir_legal_s    = ({1'b0, ir_reg_r} < (IR_WIDTH + 1)'(NUM_CH));
    overrun_set_s = udr_p_r && (state_r == PEND);
    bad_ir_set_s  = (state_r == PEND) && !ir_legal_s;
  end

  // Strobe synchronisers; the edge pulse is registered so it is exactly one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync_r <= '0;
      udr_sync_r <= '0;
      uir_hist_r <= 1'b0;
      udr_hist_r <= 1'b0;
      uir_p_r    <= 1'b0;
      udr_p_r    <= 1'b0;
    end else begin
      uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
      udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_hist_r <= uir_sync_r[SYNC_STAGES-1];
      udr_hist_r <= udr_sync_r[SYNC_STAGES-1];
      uir_p_r    <= uir_sync_r[SYNC_STAGES-1] & ~uir_hist_r;
      udr_p_r    <= udr_sync_r[SYNC_STAGES-1] & ~udr_hist_r;
    end
  end

  // Command FSM: latch on udr_p, issue when the core is free, report errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      ir_reg_r         <= '0;
      jdo_r            <= '0;
      take_action_r    <= '0;
      take_no_action_r <= '0;
      cmd_pending_r    <= 1'b0;
      overrun_r        <= 1'b0;
      bad_ir_r         <= 1'b0;
    end else begin
      take_action_r    <= '0;
      take_no_action_r <= '0;
      if (uir_p_r) begin
        ir_reg_r <= ir_in;
      end else begin
        ir_reg_r <= ir_reg_r;
      end
      case (state_r)
        IDLE: begin
          if (udr_p_r) begin
            jdo_r         <= sr;
            cmd_pending_r <= 1'b1;
            state_r       <= PEND;
          end else begin
            state_r <= IDLE;
          end
        end
        PEND: begin
          // An illegal channel is dropped even while the core is busy.
          if (!ir_legal_s) begin
            cmd_pending_r <= 1'b0;
            state_r       <= IDLE;
          end else if (!core_busy) begin
            if (jdo_r[DATA_WIDTH-1]) begin
              take_action_r <= ch_onehot(ir_reg_r);
            end else begin
              take_no_action_r <= ch_onehot(ir_reg_r);
            end
            cmd_pending_r <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r <= PEND;
          end
        end
        default: begin
          cmd_pending_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (err_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (bad_ir_set_s) begin
        bad_ir_r <= 1'b1;
      end else if (err_clr) begin
        bad_ir_r <= 1'b0;
      end else begin
        bad_ir_r <= bad_ir_r;
      end
    end
  end

  assign jdo            = jdo_r;
  assign take_action    = take_action_r;
  assign take_no_action = take_no_action_r;
  assign cmd_pending    = cmd_pending_r;
  assign overrun        = overrun_r;
  assign bad_ir         = bad_ir_r;

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk.sv
// Bench for nios_dbg_cmd_sysclk (NUM_CH=3): directed scenarios with literal
// expectations plus randomized strobes checked every cycle against a command model.
module tb_nios_dbg_cmd_sysclk;
  localparam int IRW = 2;
  localparam int DW  = 38;
  localparam int NCH = 3;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IRW-1:0] ir_in = '0;
  logic [DW-1:0]  sr = '0;
  logic          vs_uir = 1'b0;
  logic          vs_udr = 1'b0;
  logic          core_busy = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0]  jdo;
  logic [NCH-1:0] take_action;
  logic [NCH-1:0] take_no_action;
  logic          cmd_pending;
  logic          overrun;
  logic          bad_ir;

  int vectors = 0;
  int miscompares = 0;

  nios_dbg_cmd_sysclk #(.IR_WIDTH(IRW), .DATA_WIDTH(DW), .NUM_CH(NCH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .core_busy(core_busy), .err_clr(err_clr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .cmd_pending(cmd_pending), .overrun(overrun), .bad_ir(bad_ir)
  );

  always #5 clk = ~clk;

  // Model: strobe level history (lvl[k] = level k+1 edges ago) and the command it implies.
  logic           lu [0:SS+1];
  logic           li [0:SS+1];
  logic           m_pend = 1'b0;
  logic [IRW-1:0] m_ir = '0;
  logic [DW-1:0]  m_jdo = '0;
  logic [NCH-1:0] m_ta = '0;
  logic [NCH-1:0] m_tna = '0;
  logic           m_ovr = 1'b0;
  logic           m_bad = 1'b0;

  initial for (int k = 0; k <= SS + 1; k++) begin lu[k] = 1'b0; li[k] = 1'b0; end

  always @(posedge clk or posedge reset) begin
    logic up, ip, ovr_set, bad_set;
    if (reset) begin
      for (int k = 0; k <= SS + 1; k++) begin lu[k] = 1'b0; li[k] = 1'b0; end
      m_pend = 1'b0; m_ir = '0; m_jdo = '0; m_ta = '0; m_tna = '0; m_ovr = 1'b0; m_bad = 1'b0;
    end else begin
      // A strobe rise seen at edge n is acted on at edge n+SS+1.
      up = lu[SS] & ~lu[SS+1];
      ip = li[SS] & ~li[SS+1];
      ovr_set = 1'b0; bad_set = 1'b0;
      m_ta = '0; m_tna = '0;
      if (m_pend) begin
        ovr_set = up;
        if (int'(m_ir) >= NCH) begin
          bad_set = 1'b1; m_pend = 1'b0;
        end else if (!core_busy) begin
          if (m_jdo[DW-1]) m_ta = NCH'(1 << m_ir);
          else m_tna = NCH'(1 << m_ir);
          m_pend = 1'b0;
        end
      end else if (up) begin
        m_jdo = sr; m_pend = 1'b1;
      end
      if (ip) m_ir = ir_in;
      m_ovr = ovr_set ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
      m_bad = bad_set ? 1'b1 : (err_clr ? 1'b0 : m_bad);
      for (int k = SS + 1; k > 0; k--) begin lu[k] = lu[k-1]; li[k] = li[k-1]; end
      lu[0] = vs_udr; li[0] = vs_uir;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("jdo", 64'(jdo), 64'(m_jdo));
      chk("take_action", 64'(take_action), 64'(m_ta));
      chk("take_no_action", 64'(take_no_action), 64'(m_tna));
      chk("cmd_pending", 64'(cmd_pending), 64'(m_pend));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("bad_ir", 64'(bad_ir), 64'(m_bad));
      chk("onehot", 64'($countones({take_action, take_no_action}) <= 1), 64'(1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    @(negedge clk); ir_in = v; vs_uir = 1'b1;
    cyc(2); vs_uir = 1'b0;
    cyc(4);
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += $countones({take_action, take_no_action});
    end
  endtask

  task automatic rnd_cycle();
    @(negedge clk);
    core_busy = ($urandom_range(0, 3) == 0);
    err_clr   = ($urandom_range(0, 9) == 0);
  endtask

  logic [DW-1:0] a_val, b_val;
  int cnt;

  initial begin
    cyc(3);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_pulses", 64'({take_action, take_no_action, cmd_pending, overrun, bad_ir}), 64'd0);

    // 1: action on channel 1; jdo at edge 4, pulse at edge 5.
    load_ir(2'd1);
    a_val = {1'b1, 37'h0_1234_5678};
    @(negedge clk); sr = a_val; vs_udr = 1'b1;
    cyc(4);
    chk("t1_jdo", 64'(jdo), 64'(a_val));
    chk("t1_pend", 64'(cmd_pending), 64'd1);
    chk("t1_nopulse_e4", 64'(take_action), 64'd0);
    cyc(1);
    chk("t1_ta", 64'(take_action), 64'b010);
    cyc(1);
    chk("t1_ta_once", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    cyc(4);

    // 2: no-action on channel 2 held off by core_busy.
    load_ir(2'd2);
    @(negedge clk); core_busy = 1'b1; sr = {1'b0, 37'h1_5555_AAAA}; vs_udr = 1'b1;
    cyc(4);
    vs_udr = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_pending !== 1'b1 || take_no_action !== 3'b000) cnt++;
    end
    chk("t2_held", 64'(cnt), 64'd0);
    core_busy = 1'b0;
    cyc(1);
    chk("t2_tna", 64'(take_no_action), 64'b100);
    chk("t2_pend_clr", 64'(cmd_pending), 64'd0);
    cyc(3);

    // 3: second strobe while pending sets overrun and is discarded.
    a_val = {1'b1, 37'h0_0000_00A1};
    b_val = {1'b0, 37'h0_0000_00B2};
    @(negedge clk); core_busy = 1'b1; sr = a_val; vs_udr = 1'b1;
    cyc(3); vs_udr = 1'b0;
    cyc(4);
    sr = b_val; vs_udr = 1'b1;
    cyc(2); vs_udr = 1'b0;
    cyc(5);
    chk("t3_overrun", 64'(overrun), 64'd1);
    chk("t3_jdo_kept", 64'(jdo), 64'(a_val));
    core_busy = 1'b0;
    count_pulses(8, cnt);
    chk("t3_one_pulse", 64'(cnt), 64'd1);
    err_clr = 1'b1;
    cyc(1); err_clr = 1'b0;
    chk("t3_clr", 64'(overrun), 64'd0);
    cyc(2);

    // 4: ir=3 is illegal with three channels.
    load_ir(2'd3);
    @(negedge clk); sr = {1'b1, 37'h0}; vs_udr = 1'b1;
    cyc(2); vs_udr = 1'b0;
    cyc(3);
    chk("t4_bad_ir", 64'(bad_ir), 64'd1);
    chk("t4_pend_clr", 64'(cmd_pending), 64'd0);
    count_pulses(4, cnt);
    chk("t4_no_pulse", 64'(cnt), 64'd0);

    // 5: simultaneous IR and DR update uses the new IR.
    @(negedge clk); ir_in = 2'd2; sr = {1'b1, 37'h7}; vs_uir = 1'b1; vs_udr = 1'b1;
    cyc(5);
    chk("t5_ta_ch2", 64'(take_action), 64'b100);
    vs_uir = 1'b0; vs_udr = 1'b0;
    err_clr = 1'b1;
    cyc(1); err_clr = 1'b0;
    chk("t5_bad_clr", 64'(bad_ir), 64'd0);
    cyc(3);

    // 6: reset in PEND loses the command; a long-held strobe gives one command.
    @(negedge clk); core_busy = 1'b1; sr = {1'b1, 37'h3}; vs_udr = 1'b1;
    cyc(2); vs_udr = 1'b0;
    cyc(3);
    chk("t6_pend", 64'(cmd_pending), 64'd1);
    #3 reset = 1'b1;
    #1 chk("t6_rst_imm", 64'({jdo, take_action, take_no_action, cmd_pending, overrun, bad_ir}), 64'd0);
    cyc(3);
    #3 reset = 1'b0;
    core_busy = 1'b0;
    count_pulses(10, cnt);
    chk("t6_no_pulse", 64'(cnt), 64'd0);
    @(negedge clk); vs_udr = 1'b1;
    count_pulses(30, cnt);
    chk("t6_held_one", 64'(cnt), 64'd1);
    vs_udr = 1'b0;
    cyc(4);

    // Randomized strobes, busy and error-clear traffic.
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      ir_in  = IRW'($urandom_range(0, 3));
      sr     = DW'({$urandom, $urandom});
      vs_uir = 1'($urandom_range(0, 1));
      vs_udr = 1'b1;
      repeat ($urandom_range(1, 5)) rnd_cycle();
      vs_uir = 1'b0; vs_udr = 1'b0;
      repeat ($urandom_range(1, 8)) rnd_cycle();
    end
    core_busy = 1'b0; err_clr = 1'b0;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
